// File: rtl/control_banco_pkg.sv
// Shared types and default widths for the control_banco register-file sequencer.
package control_banco_pkg;

    localparam int N_DEF = 3;
    localparam int W_DEF = 3;

    typedef enum logic [2:0] {
        OP_ADD = 3'd0,
        OP_SUB = 3'd1,
        OP_AND = 3'd2,
        OP_OR  = 3'd3,
        OP_XOR = 3'd4,
        OP_LDI = 3'd5,
        OP_NOP = 3'd6
    } op_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        EXEC  = 2'd2,
        WRITE = 2'd3
    } state_t;

    // Opcodes 6 and 7 are both NOP; everything up to LDI commits a result.
    function automatic logic op_writes(input logic [2:0] op);
        return op <= 3'(OP_LDI);
    endfunction

endpackage

// File: rtl/control_banco_if.sv
// Register-file port set: one write port and two combinational read ports.
interface control_banco_if
    import control_banco_pkg::*;
#(
    parameter int N = N_DEF,
    parameter int W = W_DEF
);

    logic         we;
    logic [N-1:0] addr_rd;
    logic [W-1:0] data_in;
    logic [N-1:0] addr_rs1;
    logic [N-1:0] addr_rs2;
    logic [W-1:0] rs1;
    logic [W-1:0] rs2;

    modport master (
        output we, addr_rd, data_in, addr_rs1, addr_rs2,
        input  rs1, rs2
    );

    modport slave (
        input  we, addr_rd, data_in, addr_rs1, addr_rs2,
        output rs1, rs2
    );

endinterface

// File: rtl/control_banco_alu.sv
// Combinational ALU for control_banco; all arithmetic wraps modulo 2**W.
module alu_banco
    import control_banco_pkg::*;
#(
    parameter int W = W_DEF
) (
    input  logic [2:0]   op,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic [W-1:0] imm,
    output logic [W-1:0] y
);

    always_comb begin
        y = '0;
        case (op)
            OP_ADD:  y = a + b;
            OP_SUB:  y = a - b;
            OP_AND:  y = a & b;
            OP_OR:   y = a | b;
            OP_XOR:  y = a ^ b;
            OP_LDI:  y = imm;
            default: y = '0;
        endcase
    end

endmodule

// File: rtl/control_banco.sv
// Read-then-write sequencer driving the register file: one operation per four cycles.
//   state | meaning
//   IDLE  | waiting for in_valid, request fields latched on accept
//   READ  | read addresses driven, operands captured at end of cycle
//   EXEC  | ALU result registered into the write-back outputs
//   WRITE | write port active (unless rd=0 or NOP), done pulses
module control_banco
    import control_banco_pkg::*;
#(
    parameter int N = N_DEF,
    parameter int W = W_DEF
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      in_op,
    input  logic [N-1:0]    in_rd,
    input  logic [N-1:0]    in_rs1,
    input  logic [N-1:0]    in_rs2,
    input  logic [W-1:0]    in_imm,
    control_banco_if.master rf,
    output logic            done,
    output logic [W-1:0]    result,
    output logic            zero
);

    localparam logic [1:0] S_IDLE  = 2'(IDLE);
    localparam logic [1:0] S_READ  = 2'(READ);
    localparam logic [1:0] S_EXEC  = 2'(EXEC);
    localparam logic [1:0] S_WRITE = 2'(WRITE);

    logic [1:0]   state;
    logic [2:0]   op_q;
    logic [N-1:0] rd_q;
    logic [W-1:0] imm_q;
    logic [W-1:0] a_q;
    logic [W-1:0] b_q;
    logic [W-1:0] alu_y;

    alu_banco #(.W(W)) u_alu (
        .op  (op_q),
        .a   (a_q),
        .b   (b_q),
        .imm (imm_q),
        .y   (alu_y)
    );

    assign in_ready = (state == S_IDLE) && !rst;

    // Read addresses double as the rs1/rs2 latches and hold outside READ.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            op_q        <= '0;
            rd_q        <= '0;
            imm_q       <= '0;
            a_q         <= '0;
            b_q         <= '0;
            rf.we       <= 1'b0;
            rf.addr_rd  <= '0;
            rf.data_in  <= '0;
            rf.addr_rs1 <= '0;
            rf.addr_rs2 <= '0;
            done        <= 1'b0;
            result      <= '0;
            zero        <= 1'b0;
        end else begin
            rf.we <= 1'b0;
            done  <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        op_q        <= in_op;
                        rd_q        <= in_rd;
                        imm_q       <= in_imm;
                        rf.addr_rs1 <= in_rs1;
                        rf.addr_rs2 <= in_rs2;
                        state       <= S_READ;
                    end
                end
                S_READ: begin
                    a_q   <= rf.rs1;
                    b_q   <= rf.rs2;
                    state <= S_EXEC;
                end
                S_EXEC: begin
                    rf.we      <= (rd_q != '0) && op_writes(op_q);
                    rf.addr_rd <= rd_q;
                    rf.data_in <= alu_y;
                    result     <= alu_y;
                    zero       <= (alu_y == '0);
                    done       <= 1'b1;
                    state      <= S_WRITE;
                end
                S_WRITE: state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
